// File: rtl/regfile_sb.sv
// Register file with two read ports, two prioritised write ports, optional
// write-through bypass and zero register, and a busy scoreboard for RAW hazards.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1,
    output logic             rbusy0,
    output logic             rbusy1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_reg,
    output logic [AW:0]      nbusy
);

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [AW:0]      nbusy_q;
    logic [AW:0]      nbusy_d;

    // Enables after dropping anything aimed at the hard-wired zero register.
    logic we0_eff;
    logic we1_eff;
    logic iss_eff;

    assign we0_eff = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign we1_eff = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign iss_eff = iss_en && !((ZERO_REG != 0) && (iss_reg == '0));

    logic [DEPTH-1:0] wr0_hit;
    logic [DEPTH-1:0] wr1_hit;
    logic [DEPTH-1:0] set_hit;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_dec
            assign wr0_hit[gi] = we0_eff && (wa0 == AW'(gi));
            assign wr1_hit[gi] = we1_eff && (wa1 == AW'(gi));
            assign set_hit[gi] = iss_eff && (iss_reg == AW'(gi));
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            rf_d[r] = rf_q[r];
            if (wr0_hit[r]) rf_d[r] = wd0;
            if (wr1_hit[r]) rf_d[r] = wd1;
        end
    end

    // A new issue is younger than any writeback, so set wins over clear.
    assign busy_d = set_hit | (busy_q & ~(wr0_hit | wr1_hit));

    // Counter tracks only real busy transitions so it always equals popcount(busy).
    logic inc;
    logic dec0;
    logic dec1;

    assign inc  = iss_eff && !busy_q[iss_reg];
    assign dec0 = we0_eff && busy_q[wa0] && !(iss_eff && (iss_reg == wa0))
                  && !(we1_eff && (wa1 == wa0));
    assign dec1 = we1_eff && busy_q[wa1] && !(iss_eff && (iss_reg == wa1));

    always_comb begin
        nbusy_d = nbusy_q + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) rf_q[r] <= '0;
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) rf_q[r] <= rf_d[r];
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    assign nbusy = nbusy_q;

    always_comb begin
        rd0    = rf_q[ra0];
        rbusy0 = busy_q[ra0];
        if (BYPASS != 0) begin
            if (we1_eff && (wa1 == ra0)) begin
                rd0    = wd1;
                rbusy0 = 1'b0;
            end else if (we0_eff && (wa0 == ra0)) begin
                rd0    = wd0;
                rbusy0 = 1'b0;
            end
        end
        // Bypass data must not leak out while reset is held.
        if (reset || ((ZERO_REG != 0) && (ra0 == '0))) begin
            rd0    = '0;
            rbusy0 = 1'b0;
        end
    end

    always_comb begin
        rd1    = rf_q[ra1];
        rbusy1 = busy_q[ra1];
        if (BYPASS != 0) begin
            if (we1_eff && (wa1 == ra1)) begin
                rd1    = wd1;
                rbusy1 = 1'b0;
            end else if (we0_eff && (wa0 == ra1)) begin
                rd1    = wd0;
                rbusy1 = 1'b0;
            end
        end
        if (reset || ((ZERO_REG != 0) && (ra1 == '0))) begin
            rd1    = '0;
            rbusy1 = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, no-bypass and zero-register builds
// share one stimulus stream; expectations are hand-computed per cycle.
module tb_regfile_sb;
    localparam int W = 16;
    localparam int D = 8;
    localparam int A = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         we0, we1, iss_en;
    logic [A-1:0] wa0, wa1, ra0, ra1, iss_reg;
    logic [W-1:0] wd0, wd1;

    logic [W-1:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;
    logic         rb0_a, rb1_a, rb0_b, rb1_b, rb0_c, rb1_c;
    logic [A:0]   nb_a, nb_b, nb_c;

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_a), .rd1(rd1_a),
        .rbusy0(rb0_a), .rbusy1(rb1_a),
        .iss_en(iss_en), .iss_reg(iss_reg), .nbusy(nb_a)
    );

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_b), .rd1(rd1_b),
        .rbusy0(rb0_b), .rbusy1(rb1_b),
        .iss_en(iss_en), .iss_reg(iss_reg), .nbusy(nb_b)
    );

    regfile_sb #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .ZERO_REG(1)) dut_c (
        .clk(clk), .reset(reset),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra0(ra0), .ra1(ra1), .rd0(rd0_c), .rd1(rd1_c),
        .rbusy0(rb0_c), .rbusy1(rb1_c),
        .iss_en(iss_en), .iss_reg(iss_reg), .nbusy(nb_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         we0;
        logic [A-1:0] wa0;
        logic [W-1:0] wd0;
        logic         we1;
        logic [A-1:0] wa1;
        logic [W-1:0] wd1;
        logic [A-1:0] ra0;
        logic [A-1:0] ra1;
        logic         iss;
        logic [A-1:0] ireg;
        logic [W-1:0] e_rd0;    // bypass build, before the edge
        logic [W-1:0] e_rd1;
        logic         e_rb0;
        logic         e_rb1;
        logic [W-1:0] e_rd0_b;  // no-bypass build, before the edge
        logic         e_rb0_b;
        logic [A:0]   e_nb;     // after the edge, both builds
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(
        input logic w0, input int a0, input int d0,
        input logic w1, input int a1, input int d1,
        input int r0, input int r1, input logic is, input int ir,
        input int erd0, input int erd1, input logic erb0, input logic erb1,
        input int erd0b, input logic erb0b, input int enb);
        vec_t v;
        v.we0 = w0;  v.wa0 = A'(a0);  v.wd0 = W'(d0);
        v.we1 = w1;  v.wa1 = A'(a1);  v.wd1 = W'(d1);
        v.ra0 = A'(r0); v.ra1 = A'(r1);
        v.iss = is;  v.ireg = A'(ir);
        v.e_rd0 = W'(erd0); v.e_rd1 = W'(erd1);
        v.e_rb0 = erb0; v.e_rb1 = erb1;
        v.e_rd0_b = W'(erd0b); v.e_rb0_b = erb0b;
        v.e_nb = (A+1)'(enb);
        return v;
    endfunction

    task automatic idle_inputs();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        iss_en = 0; iss_reg = '0;
    endtask

    initial begin
        //           we0 wa0 wd0     we1 wa1 wd1     ra0 ra1 iss ir  rd0     rd1     rb0 rb1 rd0_b   rb0_b nb
        vt[0]  = mk(1, 3, 'hBEEF, 0, 0, 0,       3, 0, 0, 0, 'hBEEF, 0,      0, 0, 0,      0, 0);
        vt[1]  = mk(0, 0, 0,      0, 0, 0,       3, 3, 0, 0, 'hBEEF, 'hBEEF, 0, 0, 'hBEEF, 0, 0);
        vt[2]  = mk(1, 5, 'h1111, 1, 5, 'h2222, 5, 3, 0, 0, 'h2222, 'hBEEF, 0, 0, 0,      0, 0);
        vt[3]  = mk(0, 0, 0,      0, 0, 0,       5, 2, 0, 0, 'h2222, 0,      0, 0, 'h2222, 0, 0);
        vt[4]  = mk(0, 0, 0,      1, 2, 'hA5A5, 2, 5, 0, 0, 'hA5A5, 'h2222, 0, 0, 0,      0, 0);
        vt[5]  = mk(0, 0, 0,      0, 0, 0,       4, 6, 1, 4, 0,      0,      0, 0, 0,      0, 1);
        vt[6]  = mk(0, 0, 0,      0, 0, 0,       4, 6, 1, 6, 0,      0,      1, 0, 0,      1, 2);
        vt[7]  = mk(1, 4, 'h0044, 0, 0, 0,       4, 6, 1, 4, 'h0044, 0,      0, 1, 0,      1, 2);
        vt[8]  = mk(0, 0, 0,      0, 0, 0,       4, 6, 0, 0, 'h0044, 0,      1, 1, 'h0044, 1, 2);
        vt[9]  = mk(0, 0, 0,      1, 6, 'h0066, 6, 4, 0, 0, 'h0066, 'h0044, 0, 1, 0,      1, 1);
        vt[10] = mk(0, 0, 0,      0, 0, 0,       6, 4, 0, 0, 'h0066, 'h0044, 0, 1, 'h0066, 0, 1);
        vt[11] = mk(1, 7, 'h7777, 0, 0, 0,       7, 1, 1, 1, 'h7777, 0,      0, 0, 0,      0, 2);
        vt[12] = mk(1, 4, 'h4444, 1, 1, 'h1001, 1, 4, 0, 0, 'h1001, 'h4444, 0, 0, 0,      1, 0);
        vt[13] = mk(0, 0, 0,      0, 0, 0,       4, 1, 0, 0, 'h4444, 'h1001, 0, 0, 'h4444, 0, 0);

        reset = 1;
        idle_inputs();
        ra0 = '0; ra1 = '0;
        #1;
        chk("rst_hold_nb_a", 32'(nb_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;

        // Reset state: every address reads zero and not busy.
        for (int i = 0; i < D; i++) begin
            ra0 = A'(i); ra1 = A'(D - 1 - i);
            #1;
            chk($sformatf("rst_rd0_a[%0d]", i), 32'(rd0_a), 0);
            chk($sformatf("rst_rd1_a[%0d]", i), 32'(rd1_a), 0);
            chk($sformatf("rst_rd0_b[%0d]", i), 32'(rd0_b), 0);
            chk($sformatf("rst_rb0_a[%0d]", i), 32'(rb0_a), 0);
            chk($sformatf("rst_rb1_b[%0d]", i), 32'(rb1_b), 0);
            $display("reset read addr %0d rd0_a=%0h rd0_b=%0h", i, rd0_a, rd0_b);
        end
        chk("rst_nb_a", 32'(nb_a), 0);
        chk("rst_nb_b", 32'(nb_b), 0);
        chk("rst_nb_c", 32'(nb_c), 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            we0 = vt[i].we0; wa0 = vt[i].wa0; wd0 = vt[i].wd0;
            we1 = vt[i].we1; wa1 = vt[i].wa1; wd1 = vt[i].wd1;
            ra0 = vt[i].ra0; ra1 = vt[i].ra1;
            iss_en = vt[i].iss; iss_reg = vt[i].ireg;
            #1;
            chk($sformatf("v%0d_rd0_a", i), 32'(rd0_a), 32'(vt[i].e_rd0));
            chk($sformatf("v%0d_rd1_a", i), 32'(rd1_a), 32'(vt[i].e_rd1));
            chk($sformatf("v%0d_rb0_a", i), 32'(rb0_a), 32'(vt[i].e_rb0));
            chk($sformatf("v%0d_rb1_a", i), 32'(rb1_a), 32'(vt[i].e_rb1));
            chk($sformatf("v%0d_rd0_b", i), 32'(rd0_b), 32'(vt[i].e_rd0_b));
            chk($sformatf("v%0d_rb0_b", i), 32'(rb0_b), 32'(vt[i].e_rb0_b));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_nb_a", i), 32'(nb_a), 32'(vt[i].e_nb));
            chk($sformatf("v%0d_nb_b", i), 32'(nb_b), 32'(vt[i].e_nb));
            $display("vec %0d ra0=%0d rd0_a=%0h rd0_b=%0h rb0_a=%0b nb_a=%0d",
                     i, ra0, rd0_a, rd0_b, rb0_a, nb_a);
        end

        // Zero register: write 0xFFFF to r0 and issue r0 in the same cycle.
        @(negedge clk);
        idle_inputs();
        we0 = 1; wa0 = '0; wd0 = 16'hFFFF;
        iss_en = 1; iss_reg = '0;
        ra0 = '0; ra1 = '0;
        #1;
        chk("z_pre_rd0_c", 32'(rd0_c), 0);
        chk("z_pre_rb0_c", 32'(rb0_c), 0);
        chk("z_pre_rd0_a", 32'(rd0_a), 32'hFFFF);
        chk("z_pre_rd0_b", 32'(rd0_b), 0);
        @(posedge clk);
        #1;
        $display("zero reg write rd0_c=%0h rd0_a=%0h nb_c=%0d nb_a=%0d", rd0_c, rd0_a, nb_c, nb_a);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("z_rd0_c", 32'(rd0_c), 0);
        chk("z_rb0_c", 32'(rb0_c), 0);
        chk("z_nb_c", 32'(nb_c), 0);
        chk("z_rd0_b", 32'(rd0_b), 32'hFFFF);
        chk("z_rb0_b", 32'(rb0_b), 1);
        chk("z_nb_a", 32'(nb_a), 1);

        // Build up three busy registers, then reset with a write in flight.
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            idle_inputs();
            iss_en = 1; iss_reg = A'(r);
            @(posedge clk);
            #1;
            $display("issue r%0d nb_a=%0d nb_c=%0d", r, nb_a, nb_c);
        end
        chk("pre_rst_nb_c", 32'(nb_c), 3);
        chk("pre_rst_nb_a", 32'(nb_a), 4);

        @(negedge clk);
        idle_inputs();
        we0 = 1; wa0 = A'(5); wd0 = 16'h5A5A;
        ra0 = A'(5); ra1 = A'(1);
        #1;
        chk("inflight_rd0_a", 32'(rd0_a), 32'h5A5A);
        chk("inflight_rb1_c", 32'(rb1_c), 1);
        #1;
        reset = 1;
        #1;
        chk("mid_rst_rd0_a", 32'(rd0_a), 0);
        chk("mid_rst_rd1_b", 32'(rd1_b), 0);
        chk("mid_rst_rb1_c", 32'(rb1_c), 0);
        chk("mid_rst_nb_a", 32'(nb_a), 0);
        chk("mid_rst_nb_b", 32'(nb_b), 0);
        chk("mid_rst_nb_c", 32'(nb_c), 0);
        $display("mid-cycle reset rd0_a=%0h nb_a=%0d nb_b=%0d nb_c=%0d", rd0_a, nb_a, nb_b, nb_c);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        idle_inputs();
        #1;
        chk("post_rst_rd0_a", 32'(rd0_a), 0);
        chk("post_rst_rd0_b", 32'(rd0_b), 0);
        chk("post_rst_rd0_c", 32'(rd0_c), 0);
        chk("post_rst_rb1_a", 32'(rb1_a), 0);
        chk("post_rst_nb_a", 32'(nb_a), 0);
        $display("after reset r5: rd0_a=%0h rd0_b=%0h rd0_c=%0h", rd0_a, rd0_b, rd0_c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the pipelined core, replacing the fixed 8×16 single-write file. It provides two combinational read ports, two write ports with fixed priority, optional write-through bypass, an optional hard-wired zero register, and a per-register busy scoreboard with an outstanding-write counter. The decode stage uses the scoreboard to detect RAW hazards; the writeback stages drive the two write ports.

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 8, number of registers; power of two, ≥2
- AW, $clog2(DEPTH), register address width (derived)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and issue
- Reset: reset, asynchronous, active-high; clock: clk.
- clk  in  1  clock
- reset  in  1  async active-high reset
- we0  in  1  write enable, port 0 (low priority)
- wa0  in  AW  write address, port 0
- wd0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (high priority)
- wa1  in  AW  write address, port 1
- wd1  in  WIDTH  write data, port 1
- ra0, ra1  in  AW  read addresses
- rd0, rd1  out  WIDTH  read data
- rbusy0, rbusy1  out  1  scoreboard busy status of ra0/ra1
- iss_en  in  1  issue: mark destination register busy
- iss_reg  in  AW  destination register of the issuing instruction
- nbusy  out  AW+1  number of registers currently busy

## Operation
- Storage: DEPTH × WIDTH registers plus a DEPTH-bit busy vector and a nbusy counter.
- Write: on a clk edge, if weN is set, `rf[waN] <= wdN`. If both ports write the same address, port 1 wins. Different addresses are both written.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped.
  - iss_en with iss_reg=0 is ignored.
  - ra=0 returns 0 and rbusy=0, regardless of BYPASS.
- Read, combinational:
  - BYPASS=0: rdN = rf[raN].
  - BYPASS=1: if we1 && wa1==raN, rdN = wd1; else if we0 && wa0==raN, rdN = wd0; else rdN = rf[raN].
- Scoreboard update per edge, for each register r:
  - Clear is the write of r by either port.
  - Set is iss_en && iss_reg==r.
  - Set dominates clear: the newly issued producer is younger than the one writing back.
  - Writes to a non-busy register are legal and leave it not busy.
- rbusyN:
  - BYPASS=0: busy[raN].
  - BYPASS=1: busy[raN] && !(any write to raN this cycle).
- nbusy: next value is the popcount of the next busy vector. It is maintained as a registered counter with increment/decrement, never by combinational recount of the outputs, and always equals the popcount of busy.
- Reset: all rf entries = 0, busy = 0, nbusy = 0. Reset mid-cycle clears immediately, including pending sets and writes.

## Timing
- Write latency: 1 edge to storage. With BYPASS=1, data is visible on rd in the same cycle, combinationally.
- Issue-to-busy: rbusy rises 1 edge after iss_en.
- Clear-to-not-busy: 1 edge after the write. Same cycle if BYPASS=1.
- Output values during and immediately after reset: rd0 = rd1 = 0, rbusy0 = rbusy1 = 0, nbusy = 0.
- No handshake: every enable is sampled each edge. Simultaneous issue and write on different registers update both.
- nbusy saturation is impossible by construction, since its range is 0..DEPTH.

## Test plan
- Reset, then read all addresses:
  - rd = 0x0000 everywhere; rbusy = 0; nbusy = 0.
  - Write r3 = 0xBEEF via port 0, then read r3 → 0xBEEF on the next cycle.
- Dual-write collision: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0x1111, wd1 = 0x2222.
  - Same cycle with BYPASS=1: rd(5) = 0x2222.
  - After the edge: rf[5] = 0x2222.
- Bypass off vs. on: write r2 = 0xA5A5 while ra0 = 2.
  - BYPASS=0: rd0 = old value, 0xA5A5 after the edge.
  - BYPASS=1: rd0 = 0xA5A5 immediately.
- Scoreboard:
  - Issue r4, then r6 → nbusy 1, then 2.
  - Write r4 while issuing r4 in the same cycle → busy[4] stays 1, nbusy = 2.
  - Write r6 → nbusy = 1, rbusy(6) = 0.
- ZERO_REG=1: write r0 = 0xFFFF and issue r0 → rd(r0) = 0, rbusy = 0, nbusy unchanged.
- Reset asserted mid-sequence with nbusy = 3 and a write in flight → all outputs 0 asynchronously; the in-flight write is not retained.
